dual_issue_queue: RTL and testbench
===================================

DUAL_ISSUE_QUEUE -- requirements
Module: dual_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 8, instruction-entry count; power of two, minimum 4.
REQ-002 Port: clk  input  1  clock, rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  fetch presents an instruction pair.
REQ-005 Port: instr_in0  input  32  older instruction of the pair.
REQ-006 Port: instr_in1  input  32  younger instruction of the pair.
REQ-007 Port: in_ready  output  1  queue can accept a pair this cycle.
REQ-008 Port: stall  input  1  downstream pipes cannot accept new issue.
REQ-009 Port: flush  input  1  discard all queued and issued instructions.
REQ-010 Port: even_valid  output  1  even_instr is valid.
REQ-011 Port: even_instr  output  32  instruction issued to the even pipe.
REQ-012 Port: odd_valid  output  1  odd_instr is valid.
REQ-013 Port: odd_instr  output  32  instruction issued to the odd pipe.
REQ-014 Port: count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Queue SHALL be a circular FIFO of DEPTH 32-bit entries with head and tail pointers that wrap modulo DEPTH.
REQ-016 Pipe class SHALL be odd when instr[31:29] is 3'b001 or 3'b010; it SHALL be even otherwise, including for all-zero NOP.
REQ-017 in_ready SHALL be 1 iff DEPTH-count >= 2, computed from the current count with no credit for same-cycle pops.
REQ-018 Push SHALL occur when in_valid and in_ready are both 1: instr_in0 is written at tail, instr_in1 at tail+1, and tail advances by 2.
REQ-019 Pushes when in_ready=0 SHALL be ignored, and the queue SHALL be unchanged by them.
REQ-020 Issue SHALL be in program order: h0 = entry at head, h1 = entry at head+1.
REQ-021 With stall=0 and count>=2, if h0 and h1 are in different classes, both SHALL issue in the same cycle, each to its own class's pipe, and head SHALL advance by 2.
REQ-022 With stall=0 and count>=2, if h0 and h1 are in the same class, only h0 SHALL issue, the other pipe's valid SHALL be 0, and head SHALL advance by 1.
REQ-023 With stall=0 and count==1, h0 SHALL issue alone and head SHALL advance by 1.
REQ-024 With stall=0 and count==0, even_valid and odd_valid SHALL be 0 at the next edge.
REQ-025 With stall=1, all outputs SHALL hold their values and no entry SHALL pop; pushes still proceed.
REQ-026 Output ports SHALL be registered. An instruction pushed at edge N SHALL be issuable no earlier than edge N+1.
REQ-027 Simultaneous push and pop in one cycle SHALL both take effect; count_next = count + pushed - popped.
REQ-028 flush=1 SHALL at the next edge clear count, head, tail, even_valid and odd_valid.
REQ-029 flush SHALL take priority over push, stall and issue in the same cycle, and the offered pair SHALL be dropped.
REQ-030 Instruction outputs SHALL retain their last value when the corresponding valid is 0.

Reset
REQ-031 rst=1 SHALL immediately force count=0, head=0, tail=0, even_valid=0, odd_valid=0, even_instr=0 and odd_instr=0, regardless of clk.
REQ-032 Reset mid-operation SHALL discard all queued entries. in_ready SHALL be 1 throughout reset and after release.
REQ-033 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Different-class pair: with the queue empty, push 0x00000001 / 0x20000000 at edge 1 -> at edge 2, even_valid=1 with even_instr=0x00000001, odd_valid=1 with odd_instr=0x20000000, and count=0.
REQ-035 Same-class pair: push 0x10000000 / 0x00000005 -> edge 2: even_instr=0x10000000 with odd_valid=0; edge 3: even_instr=0x00000005 with odd_valid=0.
REQ-036 Odd first: push 0x40000000 / 0x00000007 -> both issue at one edge, odd_instr=0x40000000 and even_instr=0x00000007.
REQ-037 Full and stall: DEPTH=8, stall=1, push 4 pairs -> count=8 and in_ready=0; a 5th pair is ignored. Release stall -> pairs drain in order, and in_ready returns to 1 once count<=6.
REQ-038 Flush with push: count=5 with flush=1 and in_valid=1 in the same cycle -> at next edge count=0 and both valids are 0; the offered pair never issues.
REQ-039 Async reset: assert rst between edges while count=6 -> valids drop to 0 before the next edge; the first push after release issues normally.

Source files
------------

// File: rtl/dual_issue_queue.sv
// Dual-issue instruction queue: circular FIFO fed with instruction pairs by fetch,
// issuing up to two instructions per cycle, in program order, to even/odd pipes.
module dual_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              instr_in0,
    input  logic [31:0]              instr_in1,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     even_valid,
    output logic [31:0]              even_instr,
    output logic                     odd_valid,
    output logic [31:0]              odd_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
    logic [31:0]   even_instr_q, even_instr_d, odd_instr_q, odd_instr_d;

    logic [31:0]   h0, h1;
    logic          h0_odd, h1_odd, push;
    logic [1:0]    pop;

    // Odd pipe takes opcode groups 001 and 010; everything else (incl. NOP) is even.
    function automatic logic is_odd(input logic [31:0] instr);
        return (instr[31:29] == 3'b001) || (instr[31:29] == 3'b010);
    endfunction

    // No credit for same-cycle pops: readiness looks only at current occupancy.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    assign h0     = mem_q[head_q];
    assign h1     = mem_q[head_q + AW'(1)];
    assign h0_odd = is_odd(h0);
    assign h1_odd = is_odd(h1);

    // Next-state: issue selection from the head, pair push at the tail, flush override.
    always_comb begin
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        even_valid_d = even_valid_q;
        odd_valid_d  = odd_valid_q;
        even_instr_d = even_instr_q;
        odd_instr_d  = odd_instr_q;
        pop          = 2'd0;
        push         = in_valid && in_ready;

        if (!stall) begin
            if (count_q == '0) begin
                even_valid_d = 1'b0;
                odd_valid_d  = 1'b0;
            end else if (count_q >= CW'(2) && h0_odd != h1_odd) begin
                // Different classes: both go, each to its own pipe.
                pop          = 2'd2;
                even_valid_d = 1'b1;
                odd_valid_d  = 1'b1;
                even_instr_d = h0_odd ? h1 : h0;
                odd_instr_d  = h0_odd ? h0 : h1;
            end else begin
                // Single issue of the oldest entry; the other pipe idles.
                pop          = 2'd1;
                even_valid_d = !h0_odd;
                odd_valid_d  = h0_odd;
                if (h0_odd) odd_instr_d  = h0;
                else        even_instr_d = h0;
            end
        end

        if (push) begin
            mem_d[tail_q]          = instr_in0;
            mem_d[tail_q + AW'(1)] = instr_in1;
            tail_d                 = tail_q + AW'(2);
        end

        head_d  = head_q + AW'(pop);
        count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);

        // Flush wins over everything; issued instruction values are kept as-is.
        if (flush) begin
            mem_d        = mem_q;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            even_valid_d = 1'b0;
            odd_valid_d  = 1'b0;
            even_instr_d = even_instr_q;
            odd_instr_d  = odd_instr_q;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            even_valid_q <= 1'b0;
            odd_valid_q  <= 1'b0;
            even_instr_q <= '0;
            odd_instr_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            even_valid_q <= even_valid_d;
            odd_valid_q  <= odd_valid_d;
            even_instr_q <= even_instr_d;
            odd_instr_q  <= odd_instr_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign even_valid = even_valid_q;
    assign odd_valid  = odd_valid_q;
    assign even_instr = even_instr_q;
    assign odd_instr  = odd_instr_q;
    assign count      = count_q;
endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_dual_issue_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr_in0 = '0;
    logic [31:0] instr_in1 = '0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        even_valid, odd_valid;
    logic [31:0] even_instr, odd_instr;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic        m_ev, m_ov;
    logic [31:0] m_ei, m_oi;

    dual_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in0(instr_in0),
        .instr_in1(instr_in1), .in_ready(in_ready), .stall(stall), .flush(flush),
        .even_valid(even_valid), .even_instr(even_instr), .odd_valid(odd_valid),
        .odd_instr(odd_instr), .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit is_odd(input logic [31:0] x);
        return (x[31:29] == 3'b001) || (x[31:29] == 3'b010);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_ev = 1'b0; m_ov = 1'b0; m_ei = '0; m_oi = '0;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic f);
        int n;
        logic [31:0] x, y;
        in_valid = v; instr_in0 = a; instr_in1 = b; stall = s; flush = f;
        if (f) begin
            mq.delete();
            m_ev = 1'b0; m_ov = 1'b0;
        end else begin
            n = mq.size();
            if (!s) begin
                if (n == 0) begin
                    m_ev = 1'b0; m_ov = 1'b0;
                end else begin
                    x = mq.pop_front();
                    if (n >= 2 && is_odd(x) != is_odd(mq[0])) begin
                        y = mq.pop_front();
                        m_ev = 1'b1; m_ov = 1'b1;
                        m_ei = is_odd(x) ? y : x;
                        m_oi = is_odd(x) ? x : y;
                    end else if (is_odd(x)) begin
                        m_ov = 1'b1; m_ev = 1'b0; m_oi = x;
                    end else begin
                        m_ev = 1'b1; m_ov = 1'b0; m_ei = x;
                    end
                end
            end
            if (v && (DEPTH - n) >= 2) begin
                mq.push_back(a);
                mq.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        m_reset();
        total++;
        if ({even_valid, odd_valid, count, in_ready} !== {1'b0, 1'b0, 4'd0, 1'b1} ||
            even_instr !== 32'h0 || odd_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset: ev=%b ov=%b cnt=%0d rdy=%b ei=%h oi=%h want 0 0 0 1 0 0",
                     even_valid, odd_valid, count, in_ready, even_instr, odd_instr);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_pairs();
        // Different-class pair, even first
        step(1, 32'h00000001, 32'h20000000, 0, 0);
        total++;
        if (count !== 4'd2 || even_valid !== 1'b0 || odd_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_push: cnt=%0d ev=%b ov=%b want 2 0 0", count, even_valid, odd_valid);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if ({even_valid, odd_valid} !== 2'b11 || even_instr !== 32'h00000001 ||
            odd_instr !== 32'h20000000 || count !== 4'd0) begin
            bad++;
            $display("FAIL diff_pair: ev=%b ei=%h ov=%b oi=%h cnt=%0d want 1 00000001 1 20000000 0",
                     even_valid, even_instr, odd_valid, odd_instr, count);
        end
        // Same-class pair issues serially
        step(1, 32'h10000000, 32'h00000005, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if (even_valid !== 1'b1 || even_instr !== 32'h10000000 || odd_valid !== 1'b0 || count !== 4'd1) begin
            bad++;
            $display("FAIL same_pair_1: ev=%b ei=%h ov=%b cnt=%0d want 1 10000000 0 1",
                     even_valid, even_instr, odd_valid, count);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (even_valid !== 1'b1 || even_instr !== 32'h00000005 || odd_valid !== 1'b0 ||
            odd_instr !== 32'h20000000) begin
            bad++;
            $display("FAIL same_pair_2: ev=%b ei=%h ov=%b oi=%h want 1 00000005 0 20000000",
                     even_valid, even_instr, odd_valid, odd_instr);
        end
        // Odd instruction first
        step(1, 32'h40000000, 32'h00000007, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if ({even_valid, odd_valid} !== 2'b11 || odd_instr !== 32'h40000000 || even_instr !== 32'h00000007) begin
            bad++;
            $display("FAIL odd_first: ev=%b ei=%h ov=%b oi=%h want 1 00000007 1 40000000",
                     even_valid, even_instr, odd_valid, odd_instr);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if ({even_valid, odd_valid} !== 2'b00 || even_instr !== 32'h00000007 || odd_instr !== 32'h40000000) begin
            bad++;
            $display("FAIL empty_idle: ev=%b ov=%b ei=%h oi=%h want 0 0 00000007 40000000",
                     even_valid, odd_valid, even_instr, odd_instr);
        end
    endtask

    task automatic test_full_stall();
        for (int k = 0; k < 4; k++) step(1, 32'h10 + k, 32'h20000010 + k, 1, 0);
        total++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full: cnt=%0d rdy=%b want 8 0", count, in_ready);
        end
        step(1, 32'h99999999, 32'h29999999, 1, 0);
        total++;
        if (count !== 4'd8 || even_valid !== 1'b0 || odd_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_ignored: cnt=%0d ev=%b ov=%b want 8 0 0", count, even_valid, odd_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if ({even_valid, odd_valid} !== 2'b11 || even_instr !== 32'h10 + k ||
                odd_instr !== 32'h20000010 + k || count !== 4'(6 - 2 * k) || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL drain[%0d]: ev=%b ei=%h ov=%b oi=%h cnt=%0d rdy=%b want 1 %h 1 %h %0d 1",
                         k, even_valid, even_instr, odd_valid, odd_instr, count, in_ready,
                         32'h10 + k, 32'h20000010 + k, 6 - 2 * k);
            end
        end
        step(0, 0, 0, 0, 0);
        total++;
        if ({even_valid, odd_valid} !== 2'b00 || count !== 4'd0) begin
            bad++;
            $display("FAIL drain_end: ev=%b ov=%b cnt=%0d want 0 0 0", even_valid, odd_valid, count);
        end
    endtask

    task automatic test_flush_push();
        for (int k = 0; k < 3; k++) step(1, 32'h100 + 2 * k, 32'h101 + 2 * k, 1, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if (count !== 4'd5 || even_valid !== 1'b1 || even_instr !== 32'h100 || odd_valid !== 1'b0) begin
            bad++;
            $display("FAIL pre_flush: cnt=%0d ev=%b ei=%h ov=%b want 5 1 00000100 0",
                     count, even_valid, even_instr, odd_valid);
        end
        step(1, 32'hDEAD0000, 32'h2EAD0000, 0, 1);
        total++;
        if (count !== 4'd0 || even_valid !== 1'b0 || odd_valid !== 1'b0 || even_instr !== 32'h100) begin
            bad++;
            $display("FAIL flush: cnt=%0d ev=%b ov=%b ei=%h want 0 0 0 00000100",
                     count, even_valid, odd_valid, even_instr);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (count !== 4'd0 || even_valid !== 1'b0 || odd_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_drop[%0d]: cnt=%0d ev=%b ov=%b want 0 0 0", k, count, even_valid, odd_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) step(1, 32'h300 + 2 * k, 32'h301 + 2 * k, 0, 0);
        step(1, 32'h310, 32'h311, 1, 0);
        total++;
        if (count !== 4'd6 || even_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: cnt=%0d ev=%b want 6 1", count, even_valid);
        end
        #3 rst = 1'b1;
        #1;
        m_reset();
        total++;
        if ({even_valid, odd_valid, count, in_ready} !== {1'b0, 1'b0, 4'd0, 1'b1} ||
            even_instr !== 32'h0 || odd_instr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: ev=%b ov=%b cnt=%0d rdy=%b ei=%h oi=%h want 0 0 0 1 0 0",
                     even_valid, odd_valid, count, in_ready, even_instr, odd_instr);
        end
        @(negedge clk) rst = 1'b0;
        step(1, 32'h00000ABC, 32'h20000DEF, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if ({even_valid, odd_valid} !== 2'b11 || even_instr !== 32'h00000ABC || odd_instr !== 32'h20000DEF) begin
            bad++;
            $display("FAIL post_reset: ev=%b ei=%h ov=%b oi=%h want 1 00000abc 1 20000def",
                     even_valid, even_instr, odd_valid, odd_instr);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            a = {3'($urandom_range(0, 7)), 29'($urandom)};
            b = {3'($urandom_range(0, 7)), 29'($urandom)};
            step(1'($urandom_range(0, 99) < 60), a, b,
                 1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 3));
            total++;
            if (even_valid !== m_ev || odd_valid !== m_ov || even_instr !== m_ei ||
                odd_instr !== m_oi || count !== 4'(mq.size()) || in_ready !== ((DEPTH - mq.size()) >= 2)) begin
                bad++;
                $display("FAIL random[%0d]: ev=%b ei=%h ov=%b oi=%h cnt=%0d rdy=%b want %b %h %b %h %0d %b",
                         i, even_valid, even_instr, odd_valid, odd_instr, count, in_ready,
                         m_ev, m_ei, m_ov, m_oi, mq.size(), (DEPTH - mq.size()) >= 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pairs();
        test_full_stall();
        test_flush_push();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
